// File: rtl/gpu_mem_pkg.sv
// Shared GPU memory-path constants.
// Used by fifo_to_dram and dram_to_fifo.
package gpu_mem_pkg;
  localparam int BURST_POWER_DEF = 3;
  localparam int BURST_MAX = 1 << BURST_POWER_DEF;
  localparam int FIFO_AW = 10;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;
endpackage

// File: rtl/fifo_to_dram_if.sv
// Avalon-MM burst write master bundle.
// master drives the bus, slave models the memory side.
interface fifo_to_dram_if;
  logic [31:0] master_address;
  logic        master_write;
  logic [31:0] master_write_data;
  logic        master_wait_request;
  logic [7:0]  master_burst_count;

  modport master (
    output master_address,
    output master_write,
    output master_write_data,
    output master_burst_count,
    input  master_wait_request
  );

  modport slave (
    input  master_address,
    input  master_write,
    input  master_write_data,
    input  master_burst_count,
    output master_wait_request
  );
endinterface

// File: rtl/gpu_dram_write.sv
// 1024x32 show-ahead FIFO feeding the DRAM write master.
// usedw wraps to 0 when full, as in a vendor scfifo.
module gpu_dram_write
  import gpu_mem_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic [31:0]        data,
  input  logic               wrreq,
  input  logic               rdreq,
  output logic [31:0]        q,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW-1:0] usedw
);
  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q;
  logic               wr_en;
  logic               rd_en;

  assign full  = cnt_q[FIFO_AW];
  assign empty = (cnt_q == '0);
  assign usedw = cnt_q[FIFO_AW-1:0];
  assign q     = mem_q[rd_ptr_q];

  // Pushes on full are dropped, pops on empty are ignored.
  assign wr_en = wrreq & ~full;
  assign rd_en = rdreq & ~empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + {{FIFO_AW{1'b0}}, wr_en}
                     - {{FIFO_AW{1'b0}}, rd_en};
    end
  end
endmodule

// File: rtl/fifo_to_dram.sv
// Drains the write FIFO to SDRAM as Avalon-MM write bursts.
// A burst only starts once all its words are already buffered.
module fifo_to_dram
  import gpu_mem_pkg::*;
#(
  parameter int BURST_POWER = $clog2(BURST_MAX)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] base_addr,
  input  logic [31:0] numWords,
  input  logic        writeVector,
  output logic        done,
  input  logic        writereq,
  input  logic [31:0] data_in,
  output logic        fifo_full,
  fifo_to_dram_if.master bus
);
  localparam logic [31:0] BMAX = 32'd1 << BURST_POWER;

  state_e      state_q;
  logic [31:0] curr_addr_q;
  logic [31:0] words_left_q;
  logic [7:0]  beats_left_q;
  logic [7:0]  burst_len_q;
  logic        write_q;

  logic [31:0]        fifo_q;
  logic               fifo_empty;
  logic               full;
  logic [FIFO_AW-1:0] usedw;
  logic [FIFO_AW:0]   avail;
  logic [31:0]        len;
  logic               start;
  logic               beat;

  gpu_dram_write u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .data   (data_in),
    .wrreq  (writereq),
    .rdreq  (beat),
    .q      (fifo_q),
    .empty  (fifo_empty),
    .full   (full),
    .usedw  (usedw)
  );

  assign avail = full ? (FIFO_AW+1)'(FIFO_DEPTH)
                      : {1'b0, usedw};
  assign len   = (words_left_q < BMAX) ? words_left_q : BMAX;
  assign start = (words_left_q != '0)
               && (32'(avail) >= len);
  assign beat  = write_q & ~bus.master_wait_request
               & ~fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      curr_addr_q  <= '0;
      words_left_q <= '0;
      beats_left_q <= '0;
      burst_len_q  <= '0;
      write_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (writeVector) begin
            curr_addr_q  <= base_addr;
            words_left_q <= numWords;
          end else if (start) begin
            burst_len_q  <= len[7:0];
            beats_left_q <= len[7:0];
            write_q      <= 1'b1;
            state_q      <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (beat) begin
            beats_left_q <= beats_left_q - 8'd1;
            words_left_q <= words_left_q - 32'd1;
            if (beats_left_q == 8'd1) begin
              write_q     <= 1'b0;
              curr_addr_q <= curr_addr_q
                           + {22'd0, burst_len_q, 2'b00};
              state_q     <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign bus.master_address     = curr_addr_q;
  assign bus.master_write       = write_q;
  assign bus.master_write_data  = fifo_q;
  assign bus.master_burst_count = burst_len_q;
  assign done      = (words_left_q == '0);
  assign fifo_full = full;
endmodule
